horner_seq_ctrl: RTL and testbench



---
 rtl/horner_seq_ctrl.sv | 157 +++++++++++++++
 tb/tb_horner_seq_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/horner_seq_ctrl.sv
// Sequencing controller for a Horner polynomial evaluator: schedules coefficient
// select, accumulator clear/enable and result strobe, with a one-deep pending-job slot.
module horner_seq_ctrl #(
    parameter int ORDER  = 10,
    parameter int CSEL_W = 4,
    parameter int PRE    = 18,
    parameter int STEP   = 16,
    parameter int POST   = 19
) (
    input  logic              clk,
    input  logic              GlobalReset,
    input  logic              srdyi,
    input  logic [CSEL_W-1:0] order_i,
    output logic [CSEL_W-1:0] coeff_sel,
    output logic              step_stb,
    output logic              sum_rst,
    output logic              sum_en,
    output logic              srdyo,
    output logic              busy,
    output logic              drop
);

    localparam int PH_W = $clog2(PRE + ORDER * STEP + POST + 1);
    localparam int SL_W = CSEL_W + 1;
    localparam logic [CSEL_W-1:0] ORD_C   = CSEL_W'(ORDER);
    localparam logic [PH_W-1:0]   PRE_PH  = PH_W'(PRE);
    localparam logic [PH_W-1:0]   STEP_PH = PH_W'(STEP);
    localparam logic [PH_W-1:0]   POST_PH = PH_W'(POST);

    typedef enum logic {IDLE, RUN} state_t;

    state_t            state, state_nxt;
    logic [PH_W-1:0]   phase, phase_d;
    logic [PH_W-1:0]   nxt_stp, nxt_stp_d;
    logic [PH_W-1:0]   done_ph, done_ph_d;
    logic [SL_W-1:0]   stp_left, stp_left_d, stp_dec;
    logic              pend, pend_d;
    logic [CSEL_W-1:0] pend_ord, pend_ord_d;
    logic [CSEL_W-1:0] coeff_sel_d, lau_ord, req_ord;
    logic              step_stb_d, sum_rst_d, sum_en_d, srdyo_d, busy_d, drop_d;
    logic              launch, launch_pend;

    function automatic logic [CSEL_W-1:0] clamp_order(input logic [CSEL_W-1:0] o);
        return (o > ORD_C) ? ORD_C : o;
    endfunction

    always_ff @(posedge clk) begin
        if (GlobalReset) begin
            state     <= IDLE;
            phase     <= '0;
            nxt_stp   <= '0;
            done_ph   <= '0;
            stp_left  <= '0;
            pend      <= 1'b0;
            coeff_sel <= ORD_C;
            step_stb  <= 1'b0;
            sum_rst   <= 1'b0;
            sum_en    <= 1'b0;
            srdyo     <= 1'b0;
            busy      <= 1'b0;
            drop      <= 1'b0;
        end else begin
            state     <= state_nxt;
            phase     <= phase_d;
            nxt_stp   <= nxt_stp_d;
            done_ph   <= done_ph_d;
            stp_left  <= stp_left_d;
            pend      <= pend_d;
            coeff_sel <= coeff_sel_d;
            step_stb  <= step_stb_d;
            sum_rst   <= sum_rst_d;
            sum_en    <= sum_en_d;
            srdyo     <= srdyo_d;
            busy      <= busy_d;
            drop      <= drop_d;
        end
        pend_ord <= pend_ord_d;
    end

    // A job may launch from IDLE, or in the srdyo cycle of the running job.
    always_comb begin
        launch_pend = (state == RUN) && srdyo && pend;
        launch      = ((state == IDLE) && srdyi) || ((state == RUN) && srdyo && (pend || srdyi));
        state_nxt   = state;
        if (launch)
            state_nxt = RUN;
        else if ((state == RUN) && srdyo)
            state_nxt = IDLE;
    end

    always_comb begin
        req_ord     = clamp_order(order_i);
        lau_ord     = launch_pend ? pend_ord : req_ord;
        stp_dec     = stp_left - SL_W'(1);
        phase_d     = phase;
        nxt_stp_d   = nxt_stp;
        done_ph_d   = done_ph;
        stp_left_d  = stp_left;
        coeff_sel_d = coeff_sel;
        step_stb_d  = 1'b0;
        sum_rst_d   = 1'b0;
        sum_en_d    = sum_en;
        srdyo_d     = 1'b0;
        busy_d      = busy;
        pend_d      = pend;
        pend_ord_d  = pend_ord;
        drop_d      = 1'b0;

        // Phase counts cycles since launch; every output is decoded from next phase.
        if (launch) begin
            phase_d    = PH_W'(1);
            nxt_stp_d  = PRE_PH;
            done_ph_d  = PRE_PH + PH_W'(lau_ord) * STEP_PH + POST_PH;
            stp_left_d = SL_W'(lau_ord) + SL_W'(1);
            sum_rst_d  = 1'b1;
            sum_en_d   = 1'b0;
            busy_d     = 1'b1;
        end else if ((state == RUN) && srdyo) begin
            busy_d   = 1'b0;
            sum_en_d = 1'b0;
        end else if (state == RUN) begin
            phase_d = phase + PH_W'(1);
            srdyo_d = (phase_d == done_ph);
            if (phase_d == nxt_stp) begin
                if (stp_left != '0) begin
                    step_stb_d  = 1'b1;
                    coeff_sel_d = stp_dec[CSEL_W-1:0];
                    stp_left_d  = stp_dec;
                    nxt_stp_d   = nxt_stp + STEP_PH;
                    sum_en_d    = 1'b1;
                end else begin
                    sum_en_d = 1'b0;
                end
            end
        end

        // In the srdyo cycle the slot either hands its job over or is refilled.
        if (state == RUN) begin
            if (srdyo) begin
                if (pend) begin
                    if (srdyi)
                        pend_ord_d = req_ord;
                    else
                        pend_d = 1'b0;
                end
            end else if (srdyi) begin
                if (pend) begin
                    drop_d = 1'b1;
                end else begin
                    pend_d     = 1'b1;
                    pend_ord_d = req_ord;
                end
            end
        end
    end

endmodule

// File: tb/tb_horner_seq_ctrl.sv
// Bench for horner_seq_ctrl: per-cycle comparison against schedules derived from job
// launch cycles, with a queue of expected srdyo cycles.
module tb_horner_seq_ctrl;

    localparam int ORDER = 10, CSEL_W = 4, PRE = 18, STEP = 16, POST = 19;
    localparam int NCASE = 8;

    logic              clk = 1'b0;
    logic              GlobalReset = 1'b1;
    logic              srdyi = 1'b0;
    logic [CSEL_W-1:0] order_i = '0;
    logic [CSEL_W-1:0] coeff_sel;
    logic              step_stb, sum_rst, sum_en, srdyo, busy, drop;

    int vectors = 0;
    int miscompares = 0;

    horner_seq_ctrl #(.ORDER(ORDER), .CSEL_W(CSEL_W), .PRE(PRE), .STEP(STEP), .POST(POST)) dut (
        .clk(clk), .GlobalReset(GlobalReset), .srdyi(srdyi), .order_i(order_i),
        .coeff_sel(coeff_sel), .step_stb(step_stb), .sum_rst(sum_rst), .sum_en(sum_en),
        .srdyo(srdyo), .busy(busy), .drop(drop)
    );

    always #5 clk = ~clk;

    // Requests: srdyi held over [rlo,rhi] with rord. Jobs: hand-derived launch cycle and order.
    typedef struct packed {
        logic [3:0][15:0] rlo;
        logic [3:0][15:0] rhi;
        logic [3:0][3:0]  rord;
        logic [2:0][15:0] jt;
        logic [2:0][3:0]  jn;
        logic [15:0]      dlo;
        logic [15:0]      dhi;
        logic [15:0]      rstc;
        logic [15:0]      len;
    } tv_t;

    tv_t tvs [NCASE];
    int  nreq [NCASE];
    int  njob [NCASE];

    function automatic int sv16(input logic [15:0] v);
        return int'($signed(v));
    endfunction

    task automatic new_case(input int k, input int len, input int rstc);
        tvs[k].rlo  = '1;
        tvs[k].rhi  = '1;
        tvs[k].rord = '0;
        tvs[k].jt   = '1;
        tvs[k].jn   = '0;
        tvs[k].dlo  = '1;
        tvs[k].dhi  = '1;
        tvs[k].rstc = 16'(rstc);
        tvs[k].len  = 16'(len);
        nreq[k] = 0;
        njob[k] = 0;
    endtask

    task automatic add_req(input int k, input int lo, input int hi, input int ord);
        tvs[k].rlo[nreq[k]]  = 16'(lo);
        tvs[k].rhi[nreq[k]]  = 16'(hi);
        tvs[k].rord[nreq[k]] = 4'(ord);
        nreq[k]++;
    endtask

    task automatic add_job(input int k, input int t, input int n);
        tvs[k].jt[njob[k]] = 16'(t);
        tvs[k].jn[njob[k]] = 4'(n);
        njob[k]++;
    endtask

    task automatic set_drop(input int k, input int lo, input int hi);
        tvs[k].dlo = 16'(lo);
        tvs[k].dhi = 16'(hi);
    endtask

    function automatic int abort_of(input tv_t tv, input int t);
        int r = sv16(tv.rstc);
        return (r >= 0 && t < r) ? r : 32'h3fff_ffff;
    endfunction

    task automatic expect_at(input tv_t tv, input int c,
                             output logic [CSEL_W-1:0] e_sel, output logic e_stb,
                             output logic e_rst, output logic e_en, output logic e_rdy,
                             output logic e_busy, output logic e_drop);
        int best = -1;
        e_sel = CSEL_W'(ORDER);
        e_stb = 0; e_rst = 0; e_en = 0; e_rdy = 0; e_busy = 0;
        for (int j = 0; j < 3; j++) begin
            int t, n, a, done, d;
            t = sv16(tv.jt[j]);
            if (t < 0) continue;
            n    = int'(tv.jn[j]);
            a    = abort_of(tv, t);
            done = t + PRE + n * STEP + POST;
            d    = c - t - PRE;
            if (c > a) continue;
            if (c == t + 1) e_rst = 1;
            if (d >= 0 && (d % STEP) == 0 && (d / STEP) <= n) e_stb = 1;
            if (d >= 0 && d < (n + 1) * STEP) e_en = 1;
            if (c == done) e_rdy = 1;
            if (c > t && c <= done) e_busy = 1;
            for (int k = 0; k <= n; k++) begin
                int sc = t + PRE + k * STEP;
                if (sc <= c && sc > best) begin
                    best  = sc;
                    e_sel = CSEL_W'(n - k);
                end
            end
        end
        e_drop = (sv16(tv.dlo) >= 0) && (c >= sv16(tv.dlo)) && (c <= sv16(tv.dhi));
    endtask

    task automatic run_case(input int k);
        tv_t tv;
        int  q[$];
        logic [CSEL_W-1:0] e_sel;
        logic e_stb, e_rst, e_en, e_rdy, e_busy, e_drop;
        tv = tvs[k];
        GlobalReset = 1'b1;
        srdyi = 1'b0;
        repeat (2) @(posedge clk);
        for (int c = 0; c <= sv16(tv.len); c++) begin
            @(posedge clk);
            #1;
            GlobalReset = (sv16(tv.rstc) >= 0) && (c == sv16(tv.rstc));
            srdyi   = 1'b0;
            order_i = CSEL_W'($urandom);
            for (int s = 3; s >= 0; s--)
                if (sv16(tv.rlo[s]) >= 0 && c >= sv16(tv.rlo[s]) && c <= sv16(tv.rhi[s])) begin
                    srdyi   = 1'b1;
                    order_i = tv.rord[s];
                end
            for (int j = 0; j < 3; j++) begin
                int t = sv16(tv.jt[j]);
                int done = t + PRE + int'(tv.jn[j]) * STEP + POST;
                if (t == c && done <= abort_of(tv, t)) q.push_back(done);
            end
            @(negedge clk);
            expect_at(tv, c, e_sel, e_stb, e_rst, e_en, e_rdy, e_busy, e_drop);
            vectors++;
            if ({coeff_sel, step_stb, sum_rst, sum_en, srdyo, busy, drop} !==
                {e_sel, e_stb, e_rst, e_en, e_rdy, e_busy, e_drop}) begin
                miscompares++;
                $display("FAIL case%0d cyc%0d: got sel=%0d stb=%b rst=%b en=%b rdy=%b busy=%b drop=%b, want sel=%0d stb=%b rst=%b en=%b rdy=%b busy=%b drop=%b",
                         k, c, coeff_sel, step_stb, sum_rst, sum_en, srdyo, busy, drop,
                         e_sel, e_stb, e_rst, e_en, e_rdy, e_busy, e_drop);
            end
            if (srdyo === 1'b1) begin
                vectors++;
                if (q.size() == 0) begin
                    miscompares++;
                    $display("FAIL case%0d srdyo_sb: got srdyo at %0d, want none pending", k, c);
                end else begin
                    int exp_c = q.pop_front();
                    if (exp_c != c) begin
                        miscompares++;
                        $display("FAIL case%0d srdyo_sb: got srdyo at %0d, want %0d", k, c, exp_c);
                    end
                end
            end
        end
        vectors++;
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL case%0d srdyo_left: got %0d results missing, want 0", k, q.size());
        end
    endtask

    initial begin
        // Single default job launched at 5.
        new_case(0, 230, -1); add_req(0, 5, 5, 10); add_job(0, 5, 10);
        // Order above ORDER clamps.
        new_case(1, 220, -1); add_req(1, 0, 0, 15); add_job(1, 0, 10);
        // Order 0: single step.
        new_case(2, 60, -1);  add_req(2, 0, 0, 0);  add_job(2, 0, 0);
        // Pending slot filled at 40, request at 41 dropped.
        new_case(3, 180, -1); add_req(3, 0, 0, 3); add_req(3, 40, 40, 2); add_req(3, 41, 41, 7);
        add_job(3, 0, 3); add_job(3, 85, 2); set_drop(3, 42, 42);
        // Start in the srdyo cycle with no pending job.
        new_case(4, 130, -1); add_req(4, 0, 0, 1); add_req(4, 53, 53, 1);
        add_job(4, 0, 1); add_job(4, 53, 1);
        // srdyo cycle with pending set and a new request: pending launches, new one queued.
        new_case(5, 180, -1); add_req(5, 0, 0, 1); add_req(5, 10, 10, 0); add_req(5, 53, 53, 2);
        add_job(5, 0, 1); add_job(5, 53, 0); add_job(5, 90, 2);
        // Reset at 100 with pending set; srdyi during reset ignored; fresh job at 110.
        new_case(6, 200, 100); add_req(6, 0, 0, 10); add_req(6, 50, 50, 3);
        add_req(6, 100, 100, 5); add_req(6, 110, 110, 2);
        add_job(6, 0, 10); add_job(6, 110, 2);
        // srdyi held high: first fills the slot, the rest drop every cycle.
        new_case(7, 130, -1); add_req(7, 0, 5, 1);
        add_job(7, 0, 1); add_job(7, 53, 1); set_drop(7, 3, 6);

        for (int k = 0; k < NCASE; k++) run_case(k);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no completion, want finish before 200000");
        $fatal(1);
    end

endmodule
